// File: rtl/inst_header_encoder.sv
// Instruction header encoder: encodes mnemonic requests into 10-bit headers, queues them
// in a FIFO and streams them with an instruction-memory address. Option macro: HDR_PARITY_EN.
module inst_header_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [3:0]        i_req_op,
  input  logic              i_req_imm,
  input  logic [2:0]        i_req_cond,
  output logic              o_hdr_valid,
  input  logic              i_hdr_ready,
  output logic [9:0]        o_hdr_data,
  output logic [ADDR_W-1:0] o_hdr_addr,
  output logic [ERR_W-1:0]  o_err_count
`ifdef HDR_PARITY_EN
  ,
  output logic              o_hdr_parity
`endif
);

  localparam int HDR_W = 10;
`ifdef HDR_PARITY_EN
  localparam int ENTRY_W = HDR_W + 1;
`else
  localparam int ENTRY_W = HDR_W;
`endif
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_SUB = 4'd1, OP_ADD = 4'd2, OP_MOV = 4'd3, OP_CMP = 4'd4,
    OP_AVR = 4'd5, OP_CUM = 4'd6, OP_STR = 4'd7, OP_LDR = 4'd8, OP_B   = 4'd9
  } op_e;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [ENTRY_W-1:0] r_head;
  logic [ADDR_W-1:0]  r_addr;
  logic [ERR_W-1:0]   r_err;

  logic [HDR_W-1:0]   w_hdr;
  logic [ENTRY_W-1:0] w_entry;
  logic               w_legal;
  logic               w_full, w_accept, w_push, w_pop, w_head_is_new;
  logic [PTR_W-1:0]   w_rd_nx;
  logic [CNT_W-1:0]   w_count_nx;
  logic [ENTRY_W-1:0] w_head_nx;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_hdr   = '0;
    w_legal = 1'b1;
    case (op_e'(i_req_op))
      OP_SUB:  w_hdr = {5'b0, i_req_imm, 4'h1};
      OP_ADD:  w_hdr = {5'b0, i_req_imm, 4'h2};
      OP_MOV:  w_hdr = {5'b0, i_req_imm, 4'h3};
      OP_CMP:  w_hdr = {5'b0, i_req_imm, 4'h7};
      OP_AVR:  begin w_hdr = 10'h00A; w_legal = !i_req_imm; end
      OP_CUM:  begin w_hdr = 10'h00B; w_legal = !i_req_imm; end
      OP_STR:  w_hdr = 10'h020;
      OP_LDR:  w_hdr = 10'h038;
      OP_B:    w_hdr = {i_req_cond, 7'h40};
      OP_NOP:  w_hdr = 10'h060;
      default: w_legal = 1'b0;
    endcase
  end

`ifdef HDR_PARITY_EN
  assign w_entry = {^w_hdr, w_hdr};
`else
  assign w_entry = w_hdr;
`endif

  // Ready comes from the registered count, so a same-cycle pop never frees a slot early.
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign o_req_ready = !w_full && !i_flush;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_push      = w_accept && w_legal;
  assign w_pop       = (r_count != '0) && i_hdr_ready && !i_flush;

  assign w_rd_nx       = r_rd_ptr + PTR_W'(w_pop);
  assign w_count_nx    = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_head_is_new = w_push && (r_count == CNT_W'(w_pop));
  assign w_head_nx     = w_head_is_new ? w_entry : r_mem[w_rd_nx];

  // NOTE: the storage array has no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_addr   <= '0;
      r_err    <= '0;
    end else begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_addr   <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop) begin
          r_rd_ptr <= w_rd_nx;
          r_addr   <= r_addr + ADDR_W'(1);
        end
        r_count <= w_count_nx;
        // Head register holds its last value once the FIFO drains.
        if (w_count_nx != '0) r_head <= w_head_nx;
      end
      if (w_accept && !w_legal && (r_err != {ERR_W{1'b1}}))
        r_err <= r_err + ERR_W'(1);
    end
  end

  assign o_hdr_valid = (r_count != '0);
  assign o_hdr_data  = r_head[HDR_W-1:0];
  assign o_hdr_addr  = r_addr;
  assign o_err_count = r_err;
`ifdef HDR_PARITY_EN
  assign o_hdr_parity = r_head[HDR_W];
`endif

endmodule

// File: tb/tb_inst_header_encoder.sv
// Self-checking bench for inst_header_encoder: directed steps plus random traffic
// compared each cycle against a queue-based reference model.
module tb_inst_header_encoder;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
  localparam int ERR_W  = 4;
  localparam int BASE [10] = '{'h060, 'h001, 'h002, 'h003, 'h007,
                               'h00A, 'h00B, 'h020, 'h038, 'h040};

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush, req_valid, req_ready, req_imm, hdr_valid, hdr_ready;
  logic [3:0]        req_op;
  logic [2:0]        req_cond;
  logic [9:0]        hdr_data;
  logic [ADDR_W-1:0] hdr_addr;
  logic [ERR_W-1:0]  err_count;
`ifdef HDR_PARITY_EN
  logic              hdr_parity;
`endif

  always #5 clk = ~clk;

  inst_header_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (flush),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op    (req_op),
    .i_req_imm   (req_imm),
    .i_req_cond  (req_cond),
    .o_hdr_valid (hdr_valid),
    .i_hdr_ready (hdr_ready),
    .o_hdr_data  (hdr_data),
    .o_hdr_addr  (hdr_addr),
    .o_err_count (err_count)
`ifdef HDR_PARITY_EN
    ,
    .o_hdr_parity(hdr_parity)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: queue of pending headers, last shown head, address and error count.
  logic [9:0]        m_q [$];
  logic [9:0]        m_last = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [ERR_W-1:0]  m_err  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic bit model_encode(input logic [3:0] op, input bit imm,
                                      input logic [2:0] cond, output logic [9:0] hdr);
    hdr = '0;
    if (op > 4'd9) return 1'b0;
    if ((op == 4'd5 || op == 4'd6) && imm) return 1'b0;
    hdr = 10'(BASE[op]);
    if (op >= 4'd1 && op <= 4'd4 && imm) hdr = hdr + 10'd16;
    if (op == 4'd9) hdr = hdr + 10'(cond) * 10'd128;
    return 1'b1;
  endfunction

  task automatic check_outputs(input bit fl);
    logic [9:0] exp_data;
    exp_data = (m_q.size() > 0) ? m_q[0] : m_last;
    check("req_ready", 32'(req_ready), 32'((m_q.size() < DEPTH) && !fl));
    check("hdr_valid", 32'(hdr_valid), 32'(m_q.size() > 0));
    check("hdr_data",  32'(hdr_data),  32'(exp_data));
    check("hdr_addr",  32'(hdr_addr),  32'(m_addr));
    check("err_count", 32'(err_count), 32'(m_err));
`ifdef HDR_PARITY_EN
    check("hdr_parity", 32'(hdr_parity), 32'(^exp_data));
`endif
  endtask

  // One clock: drive at the falling edge, check just after, then advance the model.
  task automatic cycle(input bit fl, input bit rv, input logic [3:0] op, input bit im,
                       input logic [2:0] cd, input bit hr);
    logic [9:0] h;
    bit         accept;
    @(negedge clk);
    flush = fl; req_valid = rv; req_op = op; req_imm = im; req_cond = cd; hdr_ready = hr;
    #1;
    check_outputs(fl);
    if (fl) begin
      m_q.delete();
      m_addr = '0;
    end else begin
      accept = rv && (m_q.size() < DEPTH);
      if (hr && m_q.size() > 0) begin
        void'(m_q.pop_front());
        m_addr = m_addr + 1'b1;
      end
      if (accept) begin
        if (model_encode(op, im, cd, h)) m_q.push_back(h);
        else if (m_err != {ERR_W{1'b1}}) m_err = m_err + 1'b1;
      end
    end
    if (m_q.size() > 0) m_last = m_q[0];
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    flush = 0; req_valid = 0; req_op = '0; req_imm = 0; req_cond = '0; hdr_ready = 0;
    #1;
    m_q.delete();
    m_last = '0; m_addr = '0; m_err = '0;
    check_outputs(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 0; req_valid = 0; req_op = '0; req_imm = 0; req_cond = '0; hdr_ready = 0;
    #3;
    check_outputs(1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD imm into empty FIFO appears as 0x012 at address 0 one cycle later.
    cycle(0, 1, 4'd2, 1, 3'd0, 0);
    cycle(0, 0, 4'd0, 0, 3'd0, 1);
    cycle(0, 0, 4'd0, 0, 3'd0, 0);

    // Ordered stream from a fresh address: B cond=5, LDR, SUB.
    async_reset();
    cycle(0, 1, 4'd9, 0, 3'd5, 0);
    cycle(0, 1, 4'd8, 1, 3'd7, 0);
    cycle(0, 1, 4'd1, 0, 3'd2, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 4'd0, 0, 3'd0, 1);

    // Fill past DEPTH with the consumer stalled, then pop while full.
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 1, 4'd3, i[0], 3'd0, 0);
    cycle(0, 1, 4'd7, 0, 3'd0, 1);
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 4'd0, 0, 3'd0, 1);

    // Illegal requests: accepted, not pushed, counter saturates.
    cycle(0, 1, 4'd12, 0, 3'd0, 0);
    cycle(0, 1, 4'd5, 1, 3'd0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 1, 4'd6, 1, 3'd0, 0);
    cycle(0, 0, 4'd0, 0, 3'd0, 0);

    // Streaming push+pop long enough for the address to wrap.
    for (int i = 0; i < 262; i++) cycle(0, 1, 4'd2, i[0], 3'd0, 1);
    cycle(0, 0, 4'd0, 0, 3'd0, 1);
    cycle(0, 0, 4'd0, 0, 3'd0, 1);

    // Flush with three entries; the request during flush is refused.
    for (int i = 0; i < 3; i++) cycle(0, 1, 4'd4, 1, 3'd0, 0);
    cycle(1, 1, 4'd3, 0, 3'd0, 1);
    cycle(0, 0, 4'd0, 0, 3'd0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 31) == 0), 1'($urandom), 4'($urandom_range(0, 15)),
            1'($urandom), 3'($urandom), ($urandom_range(0, 9) < 7));

    // Async reset mid-stream.
    for (int i = 0; i < 3; i++) cycle(0, 1, 4'd9, 0, 3'($urandom), 0);
    async_reset();
    cycle(0, 1, 4'd0, 0, 3'd0, 0);
    cycle(0, 0, 4'd0, 0, 3'd0, 1);
    cycle(0, 0, 4'd0, 0, 3'd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
